// File: rtl/time_keeper.sv
// time_keeper: global time counter plus periodic heartbeat sender.
// Each heartbeat is a snapshot of the time, sent as two half-width words
// over a valid/ready channel: the LSB half first, then the MSB half.
// A one-deep pending slot absorbs a beat that arrives while a message is
// still in flight. Beats beyond that are counted in a saturating drop counter.
module time_keeper #(
   parameter int NT  = 48,
   parameter int NHB = 20,
   parameter int ND  = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            unit_pulse,
   input  logic [NHB-1:0]  hb_units_per_beat,
   input  logic            time_reset_req,
   output logic [NT-1:0]   time_now,
   output logic            hb_valid,
   input  logic            hb_ready,
   output logic [NT/2-1:0] hb_payload,
   output logic            hb_is_msb,
   output logic [ND-1:0]   hb_dropped
);

   localparam int NH = NT / 2;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SEND_LO = 2'd1,
      SEND_HI = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_stateNext;
   logic [NT-1:0]   r_timeNow;
   logic [NHB-1:0]  r_hbCount;
   logic [NT-1:0]   r_snap;
   logic [NT-1:0]   w_snapNext;
   logic            r_pendValid;
   logic            w_pendValidNext;
   logic [NT-1:0]   r_pendSnap;
   logic [NT-1:0]   w_pendSnapNext;
   logic [ND-1:0]   r_dropped;
   logic [ND-1:0]   w_droppedNext;

   logic [NHB:0]    w_countInc;
   logic [NHB:0]    w_period;
   logic            w_periodZero;
   logic            w_beatDue;
   logic [NT-1:0]   w_newSnap;
   logic            w_serve;

   // The period compare is one bit wider than the count so that count+1
   // cannot wrap. A beat snapshots the time as it will be after this pulse.
   always_comb begin
      w_countInc   = {1'b0, r_hbCount} + (NHB+1)'(1);
      w_period     = {1'b0, hb_units_per_beat};
      w_periodZero = (hb_units_per_beat == '0);
      w_beatDue    = unit_pulse && !time_reset_req && !w_periodZero &&
                     (w_countInc >= w_period);
      w_newSnap    = r_timeNow + NT'(1);
   end

   // Global time: a time reset wins over a coincident unit pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timeNow <= '0;
      end else if (time_reset_req) begin
         r_timeNow <= '0;
      end else if (unit_pulse) begin
         r_timeNow <= w_newSnap;
      end
   end

   // Units since the last beat. The count is held at zero while heartbeats are disabled.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hbCount <= '0;
      end else if (time_reset_req || w_periodZero) begin
         r_hbCount <= '0;
      end else if (unit_pulse) begin
         r_hbCount <= w_beatDue ? '0 : w_countInc[NHB-1:0];
      end
   end

   // Sender state, snapshot, pending slot and drop counter registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_snap      <= '0;
         r_pendValid <= 1'b0;
         r_pendSnap  <= '0;
         r_dropped   <= '0;
      end else begin
         r_state     <= w_stateNext;
         r_snap      <= w_snapNext;
         r_pendValid <= w_pendValidNext;
         r_pendSnap  <= w_pendSnapNext;
         r_dropped   <= w_droppedNext;
      end
   end

   // Next-state logic. A serving cycle is IDLE, or the final MSB handshake.
   // In a serving cycle the pending beat goes out first, and a beat that
   // becomes due in the same cycle takes its place in the pending slot.
   // This lets messages go out back-to-back with no idle cycle between them.
   always_comb begin
      w_stateNext     = r_state;
      w_snapNext      = r_snap;
      w_pendValidNext = r_pendValid;
      w_pendSnapNext  = r_pendSnap;
      w_droppedNext   = r_dropped;
      w_serve         = (r_state == IDLE) || ((r_state == SEND_HI) && hb_ready);

      if (w_serve) begin
         if (r_pendValid) begin
            w_stateNext     = SEND_LO;
            w_snapNext      = r_pendSnap;
            w_pendValidNext = w_beatDue;
            if (w_beatDue) begin
               w_pendSnapNext = w_newSnap;
            end
         end else if (w_beatDue) begin
            w_stateNext = SEND_LO;
            w_snapNext  = w_newSnap;
         end else begin
            w_stateNext = IDLE;
         end
      end else begin
         if ((r_state == SEND_LO) && hb_ready) begin
            w_stateNext = SEND_HI;
         end
         if (w_beatDue) begin
            if (r_pendValid) begin
               if (r_dropped != '1) begin
                  w_droppedNext = r_dropped + ND'(1);
               end
            end else begin
               w_pendValidNext = 1'b1;
               w_pendSnapNext  = w_newSnap;
            end
         end
      end
   end

   // Output words are decoded from the state. The payload is held while stalled.
   always_comb begin
      hb_valid   = (r_state != IDLE);
      hb_is_msb  = (r_state == SEND_HI);
      hb_payload = '0;
      if (r_state == SEND_LO) begin
         hb_payload = r_snap[NH-1:0];
      end else if (r_state == SEND_HI) begin
         hb_payload = r_snap[NT-1:NH];
      end
      time_now   = r_timeNow;
      hb_dropped = r_dropped;
   end

endmodule

// File: doc/time_keeper.md
Name: time_keeper

Overview:
- Consumes the one-cycle time-unit pulse from the configurable unit pulser.
- Maintains the FPGA's global time in units.
- Periodically emits a heartbeat carrying the current time to the host-bound output path.
- Heartbeat is sent as two half-width words (LSB half, then MSB half) over a valid/ready channel, so the host can track FPGA time.

Parameters:
- NT, 48, width of global time counter in units; must be even.
- NHB, 20, width of heartbeat period field in units.
- ND, 8, width of dropped-heartbeat counter.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- unit_pulse  input  1  one-cycle pulse, one per time unit
- hb_units_per_beat  input  NHB  heartbeat period in units; 0 = heartbeats disabled
- time_reset_req  input  1  one-cycle request to zero global time
- time_now  output  NT  current global time in units
- hb_valid  output  1  heartbeat word valid
- hb_ready  input  1  downstream accepts word when hb_valid&hb_ready
- hb_payload  output  NT/2  heartbeat half-word
- hb_is_msb  output  1  0 = LSB half, 1 = MSB half
- hb_dropped  output  ND  saturating count of beats lost to backpressure

Behaviour:
- Reset (async, any state, mid-message included):
  - time_now=0, hb_count=0, FSM=IDLE, hb_valid=0, hb_payload=0, hb_is_msb=0, hb_dropped=0.
  - pending flag cleared; snapshot and pending registers cleared.
  - An interrupted message is lost; no partial completion after reset deasserts.
- Time counter:
  - On a cycle with unit_pulse=1, time_now <= time_now+1 (visible next cycle).
  - Wraps modulo 2^NT, no flag.
- time_reset_req:
  - Next cycle time_now=0 and hb_count=0.
  - Has priority over a same-cycle unit_pulse: result is 0, not 1, and no beat is generated from that pulse.
  - Does not abort an in-flight heartbeat (SEND_LO/SEND_HI complete with the old snapshot).
  - Does not clear the pending flag or hb_dropped.
- Beat generation (hb_units_per_beat != 0):
  - On unit_pulse (no time_reset_req): if hb_count+1 >= hb_units_per_beat, then hb_count <= 0 and the beat is due with snapshot S = time_now+1 (the new time); else hb_count <= hb_count+1.
  - Width rule: the compare is done NHB+1 bits wide.
  - Lowering the period below the current hb_count fires the beat on the next pulse.
  - hb_units_per_beat=0: hb_count held at 0, no beats. In-flight and pending beats still drain.
- FSM: IDLE, SEND_LO, SEND_HI.
  - IDLE, beat due: capture S, go SEND_LO. hb_valid=1, hb_payload=S[NT/2-1:0], hb_is_msb=0, all on the cycle after the triggering pulse (latency 1).
  - IDLE, pending set: load the pending snapshot, clear pending, go SEND_LO.
  - SEND_LO: on hb_ready, go SEND_HI; payload=S[NT-1:NT/2], hb_is_msb=1; hb_valid stays 1.
  - SEND_HI: on hb_ready, go IDLE and hb_valid=0, unless a beat is due or pending that cycle. In that case go directly to SEND_LO with the new snapshot, so there is no idle bubble.
  - While hb_valid=1 and hb_ready=0, hb_payload and hb_is_msb hold stable.
  - hb_valid never drops without a handshake except on reset.
- Backpressure:
  - A beat due while not in IDLE (and not leaving SEND_HI that cycle) is stored in the one-deep pending register (flag + snapshot).
  - A beat due while pending is already set is discarded. The older pending snapshot is kept, and hb_dropped increments, saturating at 2^ND-1.
- Simultaneous: a due beat and a pending beat in the same serving cycle → pending is served first; the new beat becomes pending.

Test Plan:
- Reset, then 5 unit_pulses 4 clks apart, hb_units_per_beat=0 → time_now steps 1..5, each update one cycle after its pulse; hb_valid stays 0.
- hb_units_per_beat=3, hb_ready=1 → on the 3rd pulse, the following cycle gives hb_valid=1, payload=3, is_msb=0; next cycle payload=0, is_msb=1; then hb_valid=0. Next beat carries 6.
- time_now preloaded near wrap (2^48-1 via pulses at NT=8 variant: 255 pulses) → next pulse gives time_now=0, no hiccup in beats.
- time_reset_req coincident with unit_pulse at time 7 → time_now=0 next cycle, hb_count=0; a beat in SEND_HI still completes with its old MSB.
- Period 1, hb_ready=0 for 10 pulses → first beat stalls in SEND_LO with payload stable, second beat is pending, remaining 8 are dropped (hb_dropped=8). Raising hb_ready → both messages drain back-to-back with no IDLE cycle between them.
- Assert reset during SEND_HI with hb_ready=0 → all outputs return to reset values immediately (async); no MSB word is emitted after release.
